// File: rtl/alu_share_arbiter_if.sv
// ============================================================================
// Module   : alu_share_arbiter_if
// Purpose  : Requester, ALU and response signals of the shared-ALU arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

interface alu_share_arbiter_if #(
    parameter int W = 8
);
    logic [3:0]     req;
    logic [11:0]    op;
    logic [4*W-1:0] a;
    logic [4*W-1:0] b;
    logic [3:0]     gnt;
    logic [2:0]     alu_sel;
    logic [W-1:0]   alu_a;
    logic [W-1:0]   alu_b;
    logic [W-1:0]   alu_y;
    logic           rsp_valid;
    logic           rsp_ready;
    logic [1:0]     rsp_id;
    logic [W-1:0]   rsp_data;
    logic           busy;

    modport slave (
        input  req, op, a, b, alu_y, rsp_ready,
        output gnt, alu_sel, alu_a, alu_b, rsp_valid, rsp_id, rsp_data, busy
    );

    modport master (
        output req, op, a, b, alu_y, rsp_ready,
        input  gnt, alu_sel, alu_a, alu_b, rsp_valid, rsp_id, rsp_data, busy
    );
endinterface

`default_nettype wire

// File: rtl/alu_share_arbiter.sv
// ============================================================================
// Module   : alu_share_arbiter
// Purpose  : Round-robin sharing of one combinational ALU among 4 requesters.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module alu_share_arbiter #(
    parameter int W       = 8,
    parameter int ALU_LAT = 1
) (
    input  wire logic             clk,
    input  wire logic             reset_n,
    alu_share_arbiter_if.slave    bus
);

    localparam logic [3:0] C_LAT_M1 = 4'(ALU_LAT - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t         r_state;
    state_t         w_state_nxt;
    logic [1:0]     r_ptr;
    logic [1:0]     r_id;
    logic [3:0]     r_cnt;
    logic [3:0]     r_gnt;
    logic [2:0]     r_sel;
    logic [W-1:0]   r_a;
    logic [W-1:0]   r_b;
    logic           r_rsp_valid;
    logic [1:0]     r_rsp_id;
    logic [W-1:0]   r_rsp_data;

    logic           w_found;
    logic [1:0]     w_win;
    logic [1:0]     w_idx;
    logic           w_launch;
    logic           w_capture;
    logic           w_release;

    // Scan from the farthest offset down so the nearest requester to r_ptr wins.
    always_comb begin
        w_found = 1'b0;
        w_win   = r_ptr;
        w_idx   = '0;
        for (int k = 3; k >= 0; k--) begin
            w_idx = r_ptr + 2'(k);
            if (bus.req[w_idx]) begin
                w_found = 1'b1;
                w_win   = w_idx;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_launch    = 1'b0;
        w_capture   = 1'b0;
        w_release   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_found) begin
                    w_launch    = 1'b1;
                    w_state_nxt = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (r_cnt == 4'd0) begin
                    w_capture   = 1'b1;
                    w_state_nxt = ST_RESP;
                end
            end
            ST_RESP: begin
                if (bus.rsp_ready) begin
                    w_release   = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // ALU operand registers are only reloaded on launch, so they hold outside EXEC.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ptr       <= '0;
            r_id        <= '0;
            r_cnt       <= '0;
            r_gnt       <= '0;
            r_sel       <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= '0;
            r_rsp_data  <= '0;
        end else begin
            r_gnt <= '0;
            if (w_launch) begin
                r_gnt <= 4'b0001 << w_win;
                r_sel <= bus.op[3*w_win +: 3];
                r_a   <= bus.a[W*w_win +: W];
                r_b   <= bus.b[W*w_win +: W];
                r_id  <= w_win;
                r_cnt <= C_LAT_M1;
            end else if (r_state == ST_EXEC && r_cnt != 4'd0) begin
                r_cnt <= r_cnt - 4'd1;
            end
            if (w_capture) begin
                r_rsp_data  <= bus.alu_y;
                r_rsp_id    <= r_id;
                r_rsp_valid <= 1'b1;
            end
            if (w_release) begin
                r_rsp_valid <= 1'b0;
                r_ptr       <= r_id + 2'd1;
            end
        end
    end

    assign bus.gnt       = r_gnt;
    assign bus.alu_sel   = r_sel;
    assign bus.alu_a     = r_a;
    assign bus.alu_b     = r_b;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_id    = r_rsp_id;
    assign bus.rsp_data  = r_rsp_data;
    assign bus.busy      = (r_state != ST_IDLE);

endmodule

`default_nettype wire
